banked_input_sram_controller: RTL and testbench
===============================================

Name: banked_input_sram_controller

Overview:
- Parametrised successor to the fixed 6-row x 2-column input SRAM controller.
- Maps a flat word address onto NUM_BANKS rows of SRAM macros, each row DATA_WIDTH/MACRO_WIDTH macros wide.
- Adds valid/ready handshakes, fully pipelined back-to-back access (one request per cycle), write-over-read arbitration, a registered read-data output, and out-of-range error reporting.
- Sits between the input-fetch engine and the input SRAM macros of the accelerator datapath.

Parameters:
- DATA_WIDTH, 64: word width seen by the client.
- MACRO_WIDTH, 32: data width of one sram macro. DATA_WIDTH must be an integer multiple.
- BANK_DEPTH, 2048: words per macro, power of two. ROW_AW = clog2(BANK_DEPTH).
- NUM_BANKS, 6: macro rows. BANK_BITS = clog2(NUM_BANKS), minimum 1.
- ADDR_WIDTH, 32: client address width. Must be at least ROW_AW + BANK_BITS.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- w_en, input, 1: write request valid.
- w_addr, input, ADDR_WIDTH: write word address.
- w_d, input, DATA_WIDTH: write data.
- w_ready, output, 1: write accepted this cycle when w_en && w_ready.
- w_done, output, 1: one-cycle pulse when a write completes.
- w_err, output, 1: qualifies w_done; the write address was out of range.
- r_en, input, 1: read request valid.
- r_addr, input, ADDR_WIDTH: read word address.
- r_ready, output, 1: read accepted this cycle when r_en && r_ready.
- r_valid, output, 1: one-cycle pulse; r_d holds the returned word.
- r_d, output, DATA_WIDTH: registered read data, held until the next r_valid.
- r_err, output, 1: qualifies r_valid; the read address was out of range.

Behaviour:
- Address decode:
  - row = addr[ROW_AW-1:0]
  - bank = addr[ROW_AW+BANK_BITS-1:ROW_AW]
  - Higher bits are ignored.
  - bank >= NUM_BANKS means out of range.
- Reset (reset low, asynchronous):
  - w_done, w_err, r_valid, r_err = 0; r_d = 0.
  - All chip selects and write enables are deasserted; the pipeline is emptied.
  - w_ready and r_ready read 0 while reset is asserted.
- Handshake:
  - w_ready = 1 whenever out of reset.
  - r_ready = !w_en.
  - Write wins over a simultaneous read. The rejected read must be held by the client and is accepted in the next cycle without a write.
- Pipeline (acceptance at edge E0, i.e. end of cycle N):
  - Stage 1, registered at E0: bank one-hot chip select, write enable, row, write data, op type, error flag. Only one bank is selected, so all other banks stay idle.
  - Macros sample at E1.
  - Write path: w_done (and w_err) is high during cycle N+2, i.e. set at E1, cleared at E2 unless another write completes.
  - Read path: the macro output of the selected bank is captured into r_d at E2; r_valid is high during cycle N+3.
  - Out-of-range write: no macro is selected; w_done=1 and w_err=1 at the same latency.
  - Out-of-range read: no macro is selected; r_d=0, r_valid=1, r_err=1 at the same latency.
- Throughput: one accepted request per cycle, sustained. Read and write completions may pulse in the same cycle.
- Ordering: a read accepted after a write to the same address returns the new data; requests take effect at the macros in acceptance order.
- Idle cycle: chip selects are deasserted (no macro power activity); r_d retains its last value.
- Reset mid-operation: in-flight requests are discarded. No w_done or r_valid is produced for them after reset is released.
- Elaboration: a static assertion fails if DATA_WIDTH % MACRO_WIDTH != 0 or ADDR_WIDTH < ROW_AW + BANK_BITS.

Test Plan:
- Defaults; write w_addr=0x1805, w_d=0xDEADBEEF_CAFEF00D -> only bank 3 is selected, row 5; w_done pulses in cycle N+2 with w_err=0.
- Read r_addr=0x1805 one cycle after that write -> r_valid in the read's cycle N+3, r_d=0xDEADBEEF_CAFEF00D, r_err=0.
- Reads of 0x0000, 0x0801, 0x1002, ... 0x2805 on consecutive cycles after filling those addresses -> r_valid high on 6 consecutive cycles with data in order; r_ready stays 1.
- w_en and r_en asserted together for 1 cycle, r_en held -> r_ready=0 in the first cycle, read accepted in the next; write completes before the read returns.
- w_addr=0x3000 (bank 6) -> w_done=1, w_err=1, no macro selected. r_addr=0x3800 -> r_valid=1, r_err=1, r_d=0.
- Issue a read, then assert reset low for 1 cycle two cycles later -> no r_valid after reset release; r_d=0, all outputs 0.

Source files
------------

// File: rtl/banked_input_sram_controller_if.sv
// banked_input_sram_controller_if
//   Client-side bus of the banked input SRAM controller.
//   master : input-fetch engine (drives requests, sees completions)
//   slave  : controller
//   Write channel : w_en, w_addr, w_d -> w_ready, w_done, w_err
//   Read channel  : r_en, r_addr      -> r_ready, r_valid, r_d, r_err
interface banked_input_sram_controller_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_d;
  logic                  w_ready;
  logic                  w_done;
  logic                  w_err;
  logic                  r_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_ready;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_d;
  logic                  r_err;

  modport master (
    output w_en, w_addr, w_d, r_en, r_addr,
    input  w_ready, w_done, w_err, r_ready, r_valid, r_d, r_err
  );

  modport slave (
    input  w_en, w_addr, w_d, r_en, r_addr,
    output w_ready, w_done, w_err, r_ready, r_valid, r_d, r_err
  );
endinterface

// File: rtl/banked_input_sram_controller.sv
// banked_input_sram_controller
//   Maps a flat word address onto NUM_BANKS rows of SRAM macros, each row
//   DATA_WIDTH/MACRO_WIDTH macros wide. One request per cycle, write wins
//   over a simultaneous read, registered read data, out-of-range reporting.
//   Ports:
//     i_clk    rising-edge clock
//     i_rst_n  asynchronous active-low reset
//     io_bus   client bus (slave modport of banked_input_sram_controller_if)
//   Latency from acceptance edge E0: macros sample at E1, w_done at E1,
//   r_d/r_valid at E2.

// Single-port synchronous SRAM macro model: write or read on a chip-select
// cycle, output holds between reads.
module bisc_sram_macro #(
  parameter int AW = 11,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_cs,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_cs) begin
      if (i_we) r_mem[i_addr] <= i_d;
      else      r_q <= r_mem[i_addr];
    end
  end

  assign o_q = r_q;
endmodule

module banked_input_sram_controller #(
  parameter int DATA_WIDTH  = 64,
  parameter int MACRO_WIDTH = 32,
  parameter int BANK_DEPTH  = 2048,
  parameter int NUM_BANKS   = 6,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  banked_input_sram_controller_if.slave  io_bus
);
  localparam int ROW_AW    = $clog2(BANK_DEPTH);
  localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int NUM_COLS  = DATA_WIDTH / MACRO_WIDTH;

  generate
    if ((DATA_WIDTH % MACRO_WIDTH) != 0 || ADDR_WIDTH < ROW_AW + BANK_BITS) begin : g_bad_cfg
      $error("banked_input_sram_controller: illegal parameter combination");
    end
  endgenerate

  // ---------------- request select / decode ----------------
  logic                           w_wready, w_rready;
  logic                           w_wr_acc, w_rd_acc;
  logic [ADDR_WIDTH-1:0]          w_addr_sel;
  logic [BANK_BITS-1:0]           w_bank;
  logic [ROW_AW-1:0]              w_row;
  logic                           w_oor;
  logic [NUM_BANKS-1:0]           w_cs;
  logic                           w_unused;

  // Readies are combinational so the client sees 0 for the whole reset.
  assign w_wready = i_rst_n;
  assign w_rready = i_rst_n & ~io_bus.w_en;
  assign io_bus.w_ready = w_wready;
  assign io_bus.r_ready = w_rready;

  assign w_wr_acc   = io_bus.w_en & w_wready;
  assign w_rd_acc   = io_bus.r_en & w_rready;
  assign w_addr_sel = w_wr_acc ? io_bus.w_addr : io_bus.r_addr;
  assign w_row      = w_addr_sel[ROW_AW-1:0];
  assign w_bank     = w_addr_sel[ROW_AW+BANK_BITS-1:ROW_AW];
  assign w_oor      = 32'(w_bank) >= NUM_BANKS;
  // Address bits above the bank field are don't-care.
  assign w_unused   = ^w_addr_sel;

  // Out-of-range banks match no index, so they select nothing.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_dec
    assign w_cs[b] = (w_wr_acc | w_rd_acc) & (w_bank == BANK_BITS'(b));
  end

  // ---------------- stage 1: macro command registers ----------------
  logic [NUM_BANKS-1:0]  r_s1_cs;
  logic                  r_s1_we;
  logic [ROW_AW-1:0]     r_s1_row;
  logic [DATA_WIDTH-1:0] r_s1_wd;
  logic                  r_wr_s1;
  // read valid / error travel as shift registers, index = stage
  logic [2:1]            r_rd_vld_pipe;
  logic [2:1]            r_err_pipe;
  logic [NUM_BANKS-1:0]  r_s2_cs;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_cs       <= '0;
      r_s1_we       <= 1'b0;
      r_s1_row      <= '0;
      r_s1_wd       <= '0;
      r_wr_s1       <= 1'b0;
      r_rd_vld_pipe <= '0;
      r_err_pipe    <= '0;
      r_s2_cs       <= '0;
    end else begin
      r_s1_cs          <= w_cs;
      r_s1_we          <= w_wr_acc;
      r_s1_row         <= w_row;
      if (w_wr_acc) r_s1_wd <= io_bus.w_d;
      r_wr_s1          <= w_wr_acc;
      r_rd_vld_pipe[1] <= w_rd_acc;
      r_err_pipe[1]    <= (w_wr_acc | w_rd_acc) & w_oor;
      r_rd_vld_pipe[2] <= r_rd_vld_pipe[1];
      r_err_pipe[2]    <= r_err_pipe[1];
      r_s2_cs          <= r_s1_cs & {NUM_BANKS{~r_s1_we}};
    end
  end

  // ---------------- macro array ----------------
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] w_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      bisc_sram_macro #(.AW(ROW_AW), .DW(MACRO_WIDTH)) u_macro (
        .i_clk  (i_clk),
        .i_cs   (r_s1_cs[b]),
        .i_we   (r_s1_we),
        .i_addr (r_s1_row),
        .i_d    (r_s1_wd[c*MACRO_WIDTH +: MACRO_WIDTH]),
        .o_q    (w_q[b][c*MACRO_WIDTH +: MACRO_WIDTH])
      );
    end
  end

  // One-hot AND-OR select of the bank that was read.
  logic [DATA_WIDTH-1:0] w_rd_mux;
  always_comb begin
    w_rd_mux = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (r_s2_cs[b]) w_rd_mux = w_rd_mux | w_q[b];
  end

  // ---------------- completion outputs ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      io_bus.w_done  <= 1'b0;
      io_bus.w_err   <= 1'b0;
      io_bus.r_valid <= 1'b0;
      io_bus.r_err   <= 1'b0;
      io_bus.r_d     <= '0;
    end else begin
      io_bus.w_done  <= r_wr_s1;
      io_bus.w_err   <= r_wr_s1 & r_err_pipe[1];
      io_bus.r_valid <= r_rd_vld_pipe[2];
      io_bus.r_err   <= r_rd_vld_pipe[2] & r_err_pipe[2];
      // r_d only moves on a returned read; an out-of-range read returns 0.
      if (r_rd_vld_pipe[2]) io_bus.r_d <= r_err_pipe[2] ? '0 : w_rd_mux;
    end
  end
endmodule

// File: tb/tb_banked_input_sram_controller.sv
// Testbench for banked_input_sram_controller: scoreboard queues filled at
// request acceptance, drained by a negedge monitor on w_done / r_valid.
module tb_banked_input_sram_controller;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  banked_input_sram_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  banked_input_sram_controller #(
    .DATA_WIDTH(64), .MACRO_WIDTH(32), .BANK_DEPTH(2048), .NUM_BANKS(6), .ADDR_WIDTH(32)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct { logic [63:0] d; logic err; int cyc; } rexp_t;
  typedef struct { logic err; int cyc; } wexp_t;
  rexp_t rq[$];
  wexp_t wq[$];
  logic [63:0] model [int];
  int          wlist[$];
  logic [63:0] last_rd = '0;

  function automatic logic oor(input logic [31:0] a);
    return ((a >> 11) & 32'd7) >= 32'd6;
  endfunction
  function automatic int key(input logic [31:0] a);
    return int'(a & 32'h3FFF);
  endfunction

  // Completion monitor
  always @(negedge clk) begin
    rexp_t re;
    wexp_t we;
    if (rst_n) begin
      if (bus.w_done) begin
        if (wq.size() == 0) chk("w_done_unexp", 1, 0);
        else begin
          we = wq.pop_front();
          chk("w_err", bus.w_err, we.err);
          chk("w_lat", cyc, we.cyc);
        end
      end
      if (bus.r_valid) begin
        if (rq.size() == 0) chk("r_valid_unexp", 1, 0);
        else begin
          re = rq.pop_front();
          chk("r_d", bus.r_d, re.d);
          chk("r_err", bus.r_err, re.err);
          chk("r_lat", cyc, re.cyc);
          last_rd = re.d;
        end
      end
    end
  end

  // One bus cycle; called just after a rising edge, returns just after the next.
  task automatic drive(input logic we, input logic [31:0] wa, input logic [63:0] wd,
                       input logic re, input logic [31:0] ra);
    wexp_t ew;
    rexp_t er;
    bus.w_en = we; bus.w_addr = wa; bus.w_d = wd;
    bus.r_en = re; bus.r_addr = ra;
    @(negedge clk);
    chk("w_ready", bus.w_ready, 1);
    chk("r_ready", bus.r_ready, {63'd0, !we});
    if (we) begin
      ew.err = oor(wa);
      ew.cyc = cyc + 2;
      wq.push_back(ew);
      if (!oor(wa)) begin
        model[key(wa)] = wd;
        wlist.push_back(int'(wa));
      end
    end else if (re) begin
      er.err = oor(ra);
      er.d   = oor(ra) ? 64'd0 : model[key(ra)];
      er.cyc = cyc + 3;
      rq.push_back(er);
    end
    @(posedge clk); #1;
    bus.w_en = 1'b0; bus.r_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [63:0] d;
    int          op;
    bus.w_en = 1'b0; bus.w_addr = '0; bus.w_d = '0;
    bus.r_en = 1'b0; bus.r_addr = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_ready", bus.w_ready, 0);
    chk("rst_r_ready", bus.r_ready, 0);
    chk("rst_w_done",  bus.w_done, 0);
    chk("rst_w_err",   bus.w_err, 0);
    chk("rst_r_valid", bus.r_valid, 0);
    chk("rst_r_err",   bus.r_err, 0);
    chk("rst_r_d",     bus.r_d, 0);
    chk("rst_cs",      dut.r_s1_cs, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single write to bank 3 row 5, then read back
    drive(1'b1, 32'h1805, 64'hDEADBEEF_CAFEF00D, 1'b0, '0);
    chk("cs_bank3", dut.r_s1_cs, 64'h08);
    chk("row5",     dut.r_s1_row, 5);
    drive(1'b0, '0, '0, 1'b1, 32'h1805);
    idle(4);

    // fill one word per bank, then six back-to-back reads
    for (int b = 0; b < 6; b++) begin
      a = (32'(b) << 11) | 32'(b);
      d = {$urandom(), $urandom()};
      drive(1'b1, a, d, 1'b0, '0);
    end
    for (int b = 0; b < 6; b++) begin
      a = (32'(b) << 11) | 32'(b);
      drive(1'b0, '0, '0, 1'b1, a);
    end
    idle(4);
    chk("cs_idle",  dut.r_s1_cs, 0);
    chk("r_d_hold", bus.r_d, last_rd);

    // write/read collision on the same address; read held one more cycle
    drive(1'b1, 32'h0802, 64'h1111_2222_3333_4444, 1'b1, 32'h0802);
    drive(1'b0, '0, '0, 1'b1, 32'h0802);
    idle(4);

    // out-of-range write and read
    drive(1'b1, 32'h3000, 64'h5555_AAAA_5555_AAAA, 1'b0, '0);
    chk("cs_oor_w", dut.r_s1_cs, 0);
    drive(1'b0, '0, '0, 1'b1, 32'h3800);
    chk("cs_oor_r", dut.r_s1_cs, 0);
    idle(4);

    // mixed random traffic, high address bits scrambled
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 4);
      if (op <= 1) begin
        if ($urandom_range(0, 7) == 0) a = (32'($urandom_range(6, 7)) << 11) | 32'($urandom_range(0, 7));
        else a = (32'($urandom_range(0, 5)) << 11) | 32'($urandom_range(0, 7));
        a = a | ($urandom() & 32'hFFFF_C000);
        drive(1'b1, a, {$urandom(), $urandom()}, (op == 1), 32'h1805);
      end else if (op <= 3) begin
        if ($urandom_range(0, 7) == 0) a = 32'h3000 | 32'($urandom_range(0, 2047));
        else a = 32'(wlist[$urandom_range(0, wlist.size() - 1)]) ^ 32'hF000_0000;
        drive(1'b0, '0, '0, 1'b1, a);
      end else begin
        idle(1);
      end
    end
    idle(5);

    // reset while a read is in flight
    drive(1'b0, '0, '0, 1'b1, 32'h1805);
    @(posedge clk); #1;
    rst_n = 1'b0;
    rq.delete();
    wq.delete();
    #1;
    chk("mid_rst_r_valid", bus.r_valid, 0);
    chk("mid_rst_r_d",     bus.r_d, 0);
    chk("mid_rst_w_ready", bus.w_ready, 0);
    chk("mid_rst_cs",      dut.r_s1_cs, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(6);
    chk("post_rst_r_d",    bus.r_d, 0);
    chk("post_rst_r_valid", bus.r_valid, 0);
    chk("post_rst_w_done", bus.w_done, 0);

    chk("rq_drained", rq.size(), 0);
    chk("wq_drained", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
